// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU issue stage: opcodes, funct fields,
// operation kinds and the issued-op record carried through the skid buffer.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] KIND_ALU     = 2'b00;
  localparam logic [1:0] KIND_BRANCH  = 2'b01;
  localparam logic [1:0] KIND_JUMP    = 2'b10;
  localparam logic [1:0] KIND_ILLEGAL = 2'b11;

  localparam logic [3:0] SEL_ADD = 4'b0000;
  localparam logic [3:0] SEL_SUB = 4'b1000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  selectop;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  kind;
    logic [2:0]  brcond;
    logic        illegal;
  } issue_op_t;

  function automatic logic [31:0] imm_i_sext(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into ALU operands and issue metadata.
// ALU_ILLEGAL_TRAP_EN: illegal ops issue as KIND_ILLEGAL instead of a NOP.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit FORCE_X0_ZERO = 1'b1
) (
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output issue_op_t   op_o
);

  logic [6:0]  opcode;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        rd_nz;
  logic        legal;
  issue_op_t   dec;

  assign opcode  = instr_i[6:0];
  assign rd      = instr_i[11:7];
  assign f3      = instr_i[14:12];
  assign rs1_idx = instr_i[19:15];
  assign rs2_idx = instr_i[24:20];
  assign f7      = instr_i[31:25];
  assign rd_nz   = (rd != 5'd0);
  assign rs1_val = (FORCE_X0_ZERO && (rs1_idx == 5'd0)) ? 32'd0 : rs1_data_i;
  assign rs2_val = (FORCE_X0_ZERO && (rs2_idx == 5'd0)) ? 32'd0 : rs2_data_i;

  // Opcode decode, assuming legality unless a field check rejects it
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.a        = rs1_val;
        dec.b        = rs2_val;
        dec.selectop = {f7[5], f3};
        dec.rd       = rd;
        dec.we       = rd_nz;
        if (f7 == F7_ZERO) begin
          legal = 1'b1;
        end else if ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL))) begin
          legal = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OPIMM: begin
        dec.a  = rs1_val;
        dec.rd = rd;
        dec.we = rd_nz;
        if ((f3 == F3_SLL) || (f3 == F3_SRL)) begin
          dec.b = {27'd0, instr_i[24:20]};
        end else begin
          dec.b = imm_i_sext(instr_i);
        end
        if (f3 == F3_SRL) begin
          dec.selectop = {f7[5], f3};
          legal        = (f7 == F7_ZERO) || (f7 == F7_ALT);
        end else if (f3 == F3_SLL) begin
          dec.selectop = {1'b0, f3};
          legal        = (f7 == F7_ZERO);
        end else begin
          dec.selectop = {1'b0, f3};
          legal        = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.b  = imm_u(instr_i);
        dec.rd = rd;
        dec.we = rd_nz;
      end
      OPC_AUIPC: begin
        dec.a  = pc_i;
        dec.b  = imm_u(instr_i);
        dec.rd = rd;
        dec.we = rd_nz;
      end
      OPC_BRANCH: begin
        // rd bits hold branch offset here, so no destination is reported
        dec.a        = rs1_val;
        dec.b        = rs2_val;
        dec.selectop = SEL_SUB;
        dec.kind     = KIND_BRANCH;
        dec.brcond   = f3;
        legal        = (f3 != F3_SLT) && (f3 != F3_SLTU);
      end
      OPC_JAL: begin
        dec.a    = pc_i;
        dec.b    = 32'd4;
        dec.kind = KIND_JUMP;
        dec.rd   = rd;
        dec.we   = rd_nz;
      end
      OPC_JALR: begin
        dec.a    = pc_i;
        dec.b    = 32'd4;
        dec.kind = KIND_JUMP;
        dec.rd   = rd;
        dec.we   = rd_nz;
        legal    = (f3 == F3_ADD);
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Illegal ops become a trap record or a plain NOP depending on the build
  always_comb begin
    op_o = dec;
    if (!legal) begin
`ifdef ALU_ILLEGAL_TRAP_EN
      op_o         = '0;
      op_o.kind    = KIND_ILLEGAL;
      op_o.illegal = 1'b1;
`else
      op_o         = '0;
`endif
    end else begin
      op_o = dec;
    end
  end

endmodule

// File: rtl/alu_op_issue.sv
// Decode/issue stage: decodes an instruction and issues it through a
// 2-entry skid buffer. Honors ALU_ILLEGAL_TRAP_EN via alu_op_decode.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter bit FORCE_X0_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_selectop,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic [1:0]  out_kind,
  output logic [2:0]  out_brcond,
  output logic        out_illegal
);

  issue_op_t dec_op;
  issue_op_t e0_q, e0_d;
  issue_op_t e1_q, e1_d;
  logic      v0_q, v0_d;
  logic      v1_q, v1_d;
  logic      in_ready_q;
  logic      acc;
  logic      xfer;

  alu_op_decode #(
    .FORCE_X0_ZERO(FORCE_X0_ZERO)
  ) u_decode (
    .instr_i    (in_instr),
    .pc_i       (in_pc),
    .rs1_data_i (in_rs1_data),
    .rs2_data_i (in_rs2_data),
    .op_o       (dec_op)
  );

  assign acc  = in_valid & in_ready_q;
  assign xfer = v0_q & out_ready;

  // Skid buffer next state: entry0 feeds the outputs, entry1 absorbs stalls
  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    if (acc && !xfer) begin
      if (!v0_q) begin
        e0_d = dec_op;
        v0_d = 1'b1;
      end else begin
        e1_d = dec_op;
        v1_d = 1'b1;
      end
    end else if (!acc && xfer) begin
      e0_d = e1_q;
      v0_d = v1_q;
      v1_d = 1'b0;
    end else if (acc && xfer) begin
      if (!v1_q) begin
        e0_d = dec_op;
      end else begin
        e0_d = e1_q;
        e1_d = dec_op;
      end
    end else begin
      e0_d = e0_q;
    end
  end

  // Entry state and registered ready; ready tracks skid occupancy only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q       <= '0;
      e1_q       <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      in_ready_q <= ~v1_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = v0_q;
  assign out_a        = e0_q.a;
  assign out_b        = e0_q.b;
  assign out_selectop = e0_q.selectop;
  assign out_rd       = e0_q.rd;
  assign out_we       = e0_q.we;
  assign out_kind     = e0_q.kind;
  assign out_brcond   = e0_q.brcond;
  assign out_illegal  = e0_q.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: directed cases plus randomized
// traffic against a queue-based reference model of the issue stage.
`timescale 1ns/1ps
module tb_alu_op_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data, out_a, out_b;
  logic [3:0]  out_selectop;
  logic [4:0]  out_rd;
  logic        out_we, out_illegal;
  logic [1:0]  out_kind;
  logic [2:0]  out_brcond;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  kind;
    logic [2:0]  brc;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_op_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_selectop(out_selectop), .out_rd(out_rd), .out_we(out_we), .out_kind(out_kind),
    .out_brcond(out_brcond), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode written from the ISA field rules
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] x1, x2, immi;
    bit          legal;
    op   = ins[6:0];
    rd   = ins[11:7];
    f3   = ins[14:12];
    f7   = ins[31:25];
    x1   = (ins[19:15] == 5'd0) ? 32'd0 : r1;
    x2   = (ins[24:20] == 5'd0) ? 32'd0 : r2;
    immi = $signed(ins) >>> 20;
    e     = '0;
    legal = 1'b1;
    case (op)
      7'h33: begin
        e.a = x1; e.b = x2; e.sel = {f7[5], f3}; e.rd = rd; e.we = (rd != 5'd0);
        legal = (f7 == 7'd0) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h13: begin
        e.a = x1; e.rd = rd; e.we = (rd != 5'd0);
        e.b = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : immi;
        e.sel = {(f3 == 3'd5) & f7[5], f3};
        if (f3 == 3'd1) legal = (f7 == 7'd0);
        else if (f3 == 3'd5) legal = (f7 == 7'd0) || (f7 == 7'd32);
        else legal = 1'b1;
      end
      7'h37: begin e.b = ins & 32'hFFFFF000; e.rd = rd; e.we = (rd != 5'd0); end
      7'h17: begin e.a = pc; e.b = ins & 32'hFFFFF000; e.rd = rd; e.we = (rd != 5'd0); end
      7'h63: begin
        e.a = x1; e.b = x2; e.sel = 4'd8; e.kind = 2'd1; e.brc = f3;
        legal = !(f3 == 3'd2 || f3 == 3'd3);
      end
      7'h6f: begin e.a = pc; e.b = 32'd4; e.kind = 2'd2; e.rd = rd; e.we = (rd != 5'd0); end
      7'h67: begin
        e.a = pc; e.b = 32'd4; e.kind = 2'd2; e.rd = rd; e.we = (rd != 5'd0);
        legal = (f3 == 3'd0);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e = '0;
`ifdef ALU_ILLEGAL_TRAP_EN
      e.kind = 2'd3;
      e.ill  = 1'b1;
`endif
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opc;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0, 1:    opc = 7'h33;
      2, 3:    opc = 7'h13;
      4:       opc = 7'h37;
      5:       opc = 7'h17;
      6:       opc = 7'h63;
      7:       opc = 7'h6f;
      8:       opc = 7'h67;
      default: opc = r[6:0];
    endcase
    if (opc == 7'h33 || opc == 7'h13) begin
      case ($urandom_range(0, 3))
        0, 1:    r[31:25] = 7'd0;
        2:       r[31:25] = 7'd32;
        default: r[31:25] = r[31:25];
      endcase
    end
    if (opc == 7'h67 && $urandom_range(0, 3) != 0) r[14:12] = 3'd0;
    if ($urandom_range(0, 7) == 0) r[19:15] = 5'd0;
    if ($urandom_range(0, 7) == 0) r[24:20] = 5'd0;
    return {r[31:7], opc};
  endfunction

  task automatic check_head();
    exp_t e;
    e = sb[0];
    chk("a", out_a, e.a);
    chk("b", out_b, e.b);
    chk("sel", 32'(out_selectop), 32'(e.sel));
    chk("rd", 32'(out_rd), 32'(e.rd));
    chk("we", 32'(out_we), 32'(e.we));
    chk("kind", 32'(out_kind), 32'(e.kind));
    chk("brcond", 32'(out_brcond), 32'(e.brc));
    chk("illegal", 32'(out_illegal), 32'(e.ill));
  endtask

  // One clock: drive at negedge, check against the model, update on posedge
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic ordy,
                       output logic acc);
    logic xf;
    exp_t e;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
    if (sb.size() > 0) check_head();
    acc = v && (sb.size() < 2);
    xf  = ordy && (sb.size() > 0);
    e   = model(ins, pc, r1, r2);
    @(posedge clk);
    if (xf) void'(sb.pop_front());
    if (acc) sb.push_back(e);
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 10 && sb.size() > 0; k++) cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc);
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic        acc, pend, v, ordy;
    logic [31:0] ri, rp, r1, r2;
    logic [31:0] bp_ops [4];
    int          idx, n;

    in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    in_rs1_data = 32'd0; in_rs2_data = 32'd0; out_ready = 1'b0;

    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_a", out_a, 32'd0);
    chk("rst_b", out_b, 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_we", 32'(out_we), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 chk("first_in_ready", 32'(in_ready), 32'd1);

    cycle(1'b1, 32'h002081B3, 32'd0, 32'd5, 32'd7, 1'b0, acc);
    #1;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    chk("add_sel", 32'(out_selectop), 32'd0);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_we", 32'(out_we), 32'd1);
    chk("add_kind", 32'(out_kind), 32'd0);

    cycle(1'b1, 32'h40335293, 32'd0, 32'h80000000, 32'h1234, 1'b1, acc);
    #1;
    chk("srai_sel", 32'(out_selectop), 32'hD);
    chk("srai_b", out_b, 32'd3);
    chk("srai_a", out_a, 32'h80000000);

    cycle(1'b1, 32'hFFF00093, 32'd0, 32'hDEADBEEF, 32'd0, 1'b1, acc);
    #1;
    chk("addi_a", out_a, 32'd0);
    chk("addi_b", out_b, 32'hFFFFFFFF);
    chk("addi_sel", 32'(out_selectop), 32'd0);

    cycle(1'b1, 32'h00209063, 32'd0, 32'd11, 32'd22, 1'b1, acc);
    #1;
    chk("bne_sel", 32'(out_selectop), 32'h8);
    chk("bne_kind", 32'(out_kind), 32'd1);
    chk("bne_brcond", 32'(out_brcond), 32'd1);
    chk("bne_we", 32'(out_we), 32'd0);

    cycle(1'b1, 32'h000000EF, 32'h100, 32'd0, 32'd0, 1'b1, acc);
    #1;
    chk("jal_a", out_a, 32'h100);
    chk("jal_b", out_b, 32'd4);
    chk("jal_kind", 32'(out_kind), 32'd2);
    chk("jal_we", 32'(out_we), 32'd1);

    cycle(1'b1, 32'h12345600, 32'h200, 32'd9, 32'd9, 1'b1, acc);
    #1;
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("ill_kind", 32'(out_kind), 32'd3);
    chk("ill_flag", 32'(out_illegal), 32'd1);
`else
    chk("nop_kind", 32'(out_kind), 32'd0);
    chk("nop_flag", 32'(out_illegal), 32'd0);
    chk("nop_a", out_a, 32'd0);
    chk("nop_b", out_b, 32'd0);
`endif
    chk("ill_we", 32'(out_we), 32'd0);
    drain();

    // Backpressure: four ops, output stalled for the first four clocks
    for (int i = 0; i < 4; i++) bp_ops[i] = 32'h00000033 | (32'(i + 1) << 7) | (32'd1 << 15);
    idx = 0;
    for (int k = 0; k < 20 && idx < 4; k++) begin
      cycle(1'b1, bp_ops[idx], 32'd0, 32'(100 + idx), 32'd0, (k >= 4) ? 1'b1 : 1'b0, acc);
      if (acc) idx++;
      if (k == 3) begin
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_hold_a", out_a, 32'd100);
        chk("bp_accepts_stalled", 32'(idx), 32'd2);
      end
    end
    chk("bp_accepts", 32'(idx), 32'd4);
    drain();

    // Full throughput
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 32'h002081B3, 32'd0, $urandom, $urandom, 1'b1, acc);
      if (acc) n++;
    end
    chk("full_rate_accepts", 32'(n), 32'd20);
    drain();

    // Randomized traffic; an unaccepted offer is held until taken
    pend = 1'b0;
    ri = 32'd0; rp = 32'd0; r1 = 32'd0; r2 = 32'd0;
    for (int k = 0; k < 1500; k++) begin
      if (!pend) begin
        ri = rand_instr(); rp = $urandom; r1 = $urandom; r2 = $urandom;
      end
      v    = pend || ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      cycle(v, ri, rp, r1, r2, ordy, acc);
      pend = v && !acc;
    end
    drain();

    // Reset mid-stream discards both entries at once
    cycle(1'b1, 32'h002081B3, 32'd0, 32'd1, 32'd2, 1'b0, acc);
    cycle(1'b1, 32'h002081B3, 32'd0, 32'd3, 32'd4, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_a", out_a, 32'd0);
    sb.delete();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    cycle(1'b1, 32'h002081B3, 32'd0, 32'd8, 32'd9, 1'b1, acc);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
